// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// FSM state encoding and the default operand width.
package mult_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shift_add_multiplier.sv
// Sequential radix-2 shift-and-add multiplier, unsigned or two's-complement.
// One product per WIDTH+2 cycles; signed operands are multiplied as magnitudes.
module shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 sgn,
    input  logic [WIDTH-1:0]     m,
    input  logic [WIDTH-1:0]     q,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   P
);

    localparam logic [WIDTH-1:0]   ONE_W    = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE_P    = (2*WIDTH)'(1);
    localparam logic [CNT_W-1:0]   ONE_C    = CNT_W'(1);
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(WIDTH - 1);

    // -2^(WIDTH-1) maps to 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit value
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                   input logic            is_signed);
        return (is_signed && x[WIDTH-1]) ? ((~x) + ONE_W) : x;
    endfunction

    function automatic logic [2*WIDTH-1:0] negate(input logic [2*WIDTH-1:0] x);
        return (~x) + ONE_P;
    endfunction

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      m_q, m_d;
    logic [WIDTH-1:0]      a_q, a_d;
    logic [WIDTH-1:0]      q_q, q_d;
    logic                  sgn_q, sgn_d;
    logic                  neg_q, neg_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [2*WIDTH-1:0]    p_q, p_d;
    logic [WIDTH:0]        sum;
    logic [2*WIDTH-1:0]    prod;

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        a_d     = a_q;
        q_d     = q_q;
        sgn_d   = sgn_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        p_d     = p_q;
        sum     = {1'b0, a_q} + (q_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
        prod    = {a_q, q_q};

        case (state_q)
            IDLE: begin
                if (start) begin
                    m_d     = magnitude(m, sgn);
                    q_d     = magnitude(q, sgn);
                    sgn_d   = sgn;
                    neg_d   = m[WIDTH-1] ^ q[WIDTH-1];
                    a_d     = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                // carry, accumulator and multiplier shift right together as one register
                a_d   = sum[WIDTH:1];
                q_d   = {sum[0], q_q[WIDTH-1:1]};
                cnt_d = cnt_q + ONE_C;
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                p_d     = (sgn_q && neg_q) ? negate(prod) : prod;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            m_q     <= '0;
            a_q     <= '0;
            q_q     <= '0;
            sgn_q   <= 1'b0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            a_q     <= a_d;
            q_q     <= q_d;
            sgn_q   <= sgn_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            p_q     <= p_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign P    = p_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed/random bench for shift_add_multiplier at WIDTH=4 and WIDTH=8,
// with a per-instance expected-product queue.
module tb_shift_add_multiplier;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start4, sgn4, busy4, done4;
    logic [3:0]  m4, q4;
    logic [7:0]  p4;
    logic        start8, sgn8, busy8, done8;
    logic [7:0]  m8, q8;
    logic [15:0] p8;

    int total = 0;
    int bad   = 0;
    logic [15:0] sb4[$];
    logic [15:0] sb8[$];

    always #5 clk = ~clk;

    shift_add_multiplier #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .sgn(sgn4),
        .m(m4), .q(q4), .busy(busy4), .done(done4), .P(p4)
    );

    shift_add_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sgn(sgn8),
        .m(m8), .q(q8), .busy(busy8), .done(done8), .P(p8)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_mul(input bit sg, input int w,
                                            input logic [7:0] a_in, input logic [7:0] b_in);
        longint one = 1;
        longint a, b;
        a = longint'(a_in) & ((one << w) - 1);
        b = longint'(b_in) & ((one << w) - 1);
        if (sg) begin
            if (a >= (one << (w - 1))) a = a - (one << w);
            if (b >= (one << (w - 1))) b = b - (one << w);
        end
        return 16'((a * b) & ((one << (2 * w)) - 1));
    endfunction

    function automatic logic busy_of(input bit w8);
        return w8 ? busy8 : busy4;
    endfunction

    function automatic logic done_of(input bit w8);
        return w8 ? done8 : done4;
    endfunction

    function automatic logic [15:0] p_of(input bit w8);
        return w8 ? p8 : {8'h00, p4};
    endfunction

    task automatic drive(input bit w8, input logic st, input logic sg,
                         input logic [7:0] mm, input logic [7:0] qq);
        if (w8) begin
            start8 = st; sgn8 = sg; m8 = mm; q8 = qq;
        end else begin
            start4 = st; sgn4 = sg; m4 = mm[3:0]; q4 = qq[3:0];
        end
    endtask

    // Called #1 after a rising edge with the DUT idle; returns #1 after the done edge.
    task automatic run_op(input string tag, input bit w8, input logic sg,
                          input logic [7:0] mm, input logic [7:0] qq);
        int w;
        int cyc;
        bit busy_ok;
        bit seen;
        logic [15:0] e;
        w = w8 ? 8 : 4;
        drive(w8, 1'b1, sg, mm, qq);
        if (w8) sb8.push_back(ref_mul(sg, 8, mm, qq));
        else    sb4.push_back(ref_mul(sg, 4, mm, qq));
        @(posedge clk); #1;
        drive(w8, 1'b0, sg, ~mm, ~qq);
        busy_ok = busy_of(w8);
        seen = 1'b0;
        cyc = 0;
        while (!seen && cyc < 4 * w) begin
            @(posedge clk); #1;
            cyc++;
            if (done_of(w8)) seen = 1'b1;
            else if (!busy_of(w8)) busy_ok = 1'b0;
        end
        chk({tag, " done seen"}, 32'(seen), 32'd1);
        chk({tag, " latency"}, 32'(cyc), 32'(w + 1));
        chk({tag, " busy while calc"}, 32'(busy_ok), 32'd1);
        chk({tag, " busy at done"}, 32'(busy_of(w8)), 32'd0);
        e = w8 ? sb8.pop_front() : sb4.pop_front();
        chk({tag, " product"}, 32'(p_of(w8)), 32'(e));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;
        int cyc;
        logic [15:0] e;
        logic [7:0] corners [7];
        corners = '{8'h00, 8'h01, 8'h02, 8'h7F, 8'h80, 8'h81, 8'hFF};

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'h0, 8'h0);
        drive(1'b1, 1'b0, 1'b0, 8'h0, 8'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy4", 32'(busy4), 32'd0);
        chk("reset done4", 32'(done4), 32'd0);
        chk("reset p4", 32'(p4), 32'd0);
        chk("reset busy8", 32'(busy8), 32'd0);
        chk("reset done8", 32'(done8), 32'd0);
        chk("reset p8", 32'(p8), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("u5x5", 1'b0, 1'b0, 8'd5, 8'd5);
        chk("u5x5 value", 32'(p4), 32'd25);

        run_op("u12x13", 1'b0, 1'b0, 8'd12, 8'd13);
        chk("u12x13 value", 32'(p4), 32'd156);
        run_op("u15x10", 1'b0, 1'b0, 8'd15, 8'd10);
        chk("u15x10 value", 32'(p4), 32'd150);
        run_op("u0x10", 1'b0, 1'b0, 8'd0, 8'd10);
        chk("u0x10 value", 32'(p4), 32'd0);

        run_op("s-3x5", 1'b0, 1'b1, 8'hD, 8'h5);
        chk("s-3x5 value", 32'(p4), 32'hF1);
        run_op("s-8x-8", 1'b0, 1'b1, 8'h8, 8'h8);
        chk("s-8x-8 value", 32'(p4), 32'h40);

        // start held high through the whole calculation with shifting operands
        drive(1'b0, 1'b1, 1'b0, 8'd3, 8'd7);
        sb4.push_back(ref_mul(1'b0, 4, 8'd3, 8'd7));
        @(posedge clk); #1;
        dones = 0;
        cyc = 0;
        while (dones == 0 && cyc < 20) begin
            drive(1'b0, 1'b1, 1'b0, 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)));
            @(posedge clk); #1;
            cyc++;
            if (done4) dones++;
        end
        start4 = 1'b0;
        chk("hold latency", 32'(cyc), 32'd5);
        e = sb4.pop_front();
        chk("hold product", 32'(p4), 32'(e));
        repeat (8) begin
            @(posedge clk); #1;
            if (done4) dones++;
        end
        chk("hold done count", 32'(dones), 32'd1);
        chk("hold P retained", 32'(p4), 32'd21);

        // reset in the second CALC cycle aborts the operation
        drive(1'b0, 1'b1, 1'b0, 8'd9, 8'd5);
        @(posedge clk); #1;
        start4 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort busy", 32'(busy4), 32'd0);
        chk("abort done", 32'(done4), 32'd0);
        chk("abort P", 32'(p4), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        dones = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done4) dones++;
        end
        chk("abort no done", 32'(dones), 32'd0);
        run_op("u9x5 after abort", 1'b0, 1'b0, 8'd9, 8'd5);
        chk("u9x5 value", 32'(p4), 32'd45);

        for (int mode = 0; mode < 2; mode++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    run_op(mode ? "w4 signed" : "w4 unsigned", 1'b0, 1'(mode), 8'(a), 8'(b));
                end
            end
        end

        run_op("w8 -128x-128", 1'b1, 1'b1, 8'h80, 8'h80);
        chk("w8 -128x-128 value", 32'(p8), 32'h4000);
        for (int mode = 0; mode < 2; mode++) begin
            for (int i = 0; i < 7; i++) begin
                for (int j = 0; j < 7; j++) begin
                    run_op(mode ? "w8 corner s" : "w8 corner u", 1'b1, 1'(mode), corners[i], corners[j]);
                end
            end
            for (int k = 0; k < 300; k++) begin
                run_op(mode ? "w8 rand s" : "w8 rand u", 1'b1, 1'(mode),
                       8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            end
        end

        chk("sb4 drained", 32'(sb4.size()), 32'd0);
        chk("sb8 drained", 32'(sb8.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
